// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, shifter FSM states and default widths.
//   SLL / SRL      : 6-bit function codes carried on the Signal input
//   state_t        : IDLE / SHIFT / DONE for the sequential shifters
//   DATA_W_DEF     : default operand width
//   SHAMT_W_DEF    : default shift-amount width (== number of barrel stages)
package alu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // True when the function code selects a logical left shift.
  function automatic logic is_sll(input logic [5:0] fn);
    return (fn == SLL);
  endfunction

endpackage

// File: rtl/shifter_sll_stage.sv
// One power-of-two stage of a left barrel shifter (combinational).
//   in    : value entering the stage
//   en    : apply this stage's shift when high, pass through otherwise
//   stage : stage index k; the shift distance is 2**k, zero-filled from bit 0
//   out   : stage result
module shifter_sll_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STG_W   = 3
) (
  input  logic [DATA_W-1:0] in,
  input  logic              en,
  input  logic [STG_W-1:0]  stage,
  output logic [DATA_W-1:0] out
);

  // Distance needs one bit more than the stage count so 2**(SHAMT_W-1) fits.
  logic [SHAMT_W:0] dist_s;

  // Decode the stage index into a shift distance and apply it when enabled.
  always_comb begin
    dist_s = {{SHAMT_W{1'b0}}, 1'b1} << stage;
    if (en) begin
      out = in << dist_s;
    end else begin
      out = in;
    end
  end

endmodule

// File: rtl/shifter_sll_seq.sv
// Multi-cycle logical left shifter: operands latched on start, one barrel
// stage applied per clock, fixed latency, one-cycle done pulse.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   start   : request, only honoured in IDLE
//   dataA   : value to shift (latched on accept)
//   dataB   : shift amount, low SHAMT_W bits used (latched on accept)
//   Signal  : function code (latched on accept); non-SLL codes yield 0
//   dataOut : registered result, held until the next completion
//   busy    : high whenever the FSM is not in IDLE
//   done    : one-cycle completion pulse
module shifter_sll_seq
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  input  logic [5:0]        Signal,
  output logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output logic              done
);

  localparam int STG_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(SHAMT_W - 1);

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   acc_r, acc_nxt_s;
  logic [SHAMT_W-1:0]  amt_r, amt_nxt_s;
  logic [STG_W-1:0]    stage_r, stage_nxt_s;
  logic                ok_r, ok_nxt_s;
  logic [DATA_W-1:0]   dout_nxt_s;
  logic                busy_nxt_s, done_nxt_s;
  logic [DATA_W-1:0]   shifted_s;
  logic                stage_en_s;

  assign stage_en_s = amt_r[stage_r];

  shifter_sll_stage #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W),
    .STG_W   (STG_W)
  ) u_stage (
    .in    (acc_r),
    .en    (stage_en_s),
    .stage (stage_r),
    .out   (shifted_s)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      acc_r   <= {DATA_W{1'b0}};
      amt_r   <= {SHAMT_W{1'b0}};
      stage_r <= {STG_W{1'b0}};
      ok_r    <= 1'b0;
      dataOut <= {DATA_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      amt_r   <= amt_nxt_s;
      stage_r <= stage_nxt_s;
      ok_r    <= ok_nxt_s;
      dataOut <= dout_nxt_s;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (stage_r == LAST_STAGE) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output next values; busy/done are derived from the next
  // state so they are registered in step with the FSM.
  always_comb begin
    acc_nxt_s   = acc_r;
    amt_nxt_s   = amt_r;
    stage_nxt_s = stage_r;
    ok_nxt_s    = ok_r;
    dout_nxt_s  = dataOut;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_nxt_s   = dataA;
          amt_nxt_s   = dataB[SHAMT_W-1:0];
          stage_nxt_s = {STG_W{1'b0}};
          ok_nxt_s    = is_sll(Signal);
        end else begin
          acc_nxt_s   = acc_r;
        end
      end
      SHIFT: begin
        acc_nxt_s   = shifted_s;
        stage_nxt_s = stage_r + {{(STG_W-1){1'b0}}, 1'b1};
        if (stage_r == LAST_STAGE) begin
          // Result is published on the same edge the last stage is applied.
          if (ok_r) begin
            dout_nxt_s = shifted_s;
          end else begin
            dout_nxt_s = {DATA_W{1'b0}};
          end
        end else begin
          dout_nxt_s = dataOut;
        end
      end
      DONE: begin
        acc_nxt_s = acc_r;
      end
      default: begin
        acc_nxt_s = acc_r;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_nxt_s == DONE);
  end

endmodule

// File: tb/tb_shifter_sll_seq.sv
module tb_shifter_sll_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  shifter_sll_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands and pulse start for one edge; returns 1 time unit after
  // the accepting edge (edge 1), with the operand inputs scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = fn;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    dataA  = 32'h5A5A5A5A;
    dataB  = 32'h00000001;
    Signal = 6'b111111;
  endtask

  // Watch edges 2..13 after an accept; counts busy cycles (including the one
  // after edge 1), done pulses, the edge of the last done, and dataOut at edge 5.
  task automatic observe(output int busy_cnt, output int done_cnt, output int done_edge,
                         output logic [31:0] pre_dout);
    busy_cnt  = busy ? 1 : 0;
    done_cnt  = done ? 1 : 0;
    done_edge = done ? 1 : 0;
    pre_dout  = 32'h0;
    for (int i = 2; i <= 13; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_edge = i;
      end
      if (i == 5) pre_dout = dataOut;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b0;
    dataA  = 32'h0;
    dataB  = 32'h0;
    Signal = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (dataOut !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: dataOut=%h busy=%b done=%b, required 0/0/0", dataOut, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (dataOut !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle[%0d]: dataOut=%h busy=%b done=%b, required 0/0/0", i, dataOut, busy, done);
      end
    end
  endtask

  task automatic test_max_shift();
    int bc, dc, de;
    logic [31:0] pd;
    start_op(32'h00000001, 32'd31, 6'b000000);
    observe(bc, dc, de, pd);
    tests_run++;
    if (bc !== 6) begin
      tests_failed++;
      $display("FAIL max_busy_cycles: got %0d, required 6", bc);
    end
    tests_run++;
    if (dc !== 1 || de !== 6) begin
      tests_failed++;
      $display("FAIL max_done: count=%0d edge=%0d, required 1 at edge 6", dc, de);
    end
    tests_run++;
    if (dataOut !== 32'h80000000) begin
      tests_failed++;
      $display("FAIL max_result: got %h, required 80000000", dataOut);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (dataOut !== 32'h80000000 || busy !== 1'b0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL max_hold[%0d]: dataOut=%h busy=%b done=%b, required 80000000/0/0", i, dataOut, busy, done);
      end
    end
  endtask

  task automatic test_amounts();
    int bc, dc, de;
    logic [31:0] pd;
    start_op(32'hDEADBEEF, 32'h00000024, 6'b000000);
    observe(bc, dc, de, pd);
    tests_run++;
    if (dataOut !== 32'hEADBEEF0 || dc !== 1 || de !== 6) begin
      tests_failed++;
      $display("FAIL amt4: dataOut=%h done_cnt=%0d edge=%0d, required EADBEEF0 1 6", dataOut, dc, de);
    end
    tests_run++;
    if (pd !== 32'h80000000) begin
      tests_failed++;
      $display("FAIL amt4_pre_hold: dataOut before done %h, required 80000000", pd);
    end
    start_op(32'hDEADBEEF, 32'h00000000, 6'b000000);
    observe(bc, dc, de, pd);
    tests_run++;
    if (dataOut !== 32'hDEADBEEF || dc !== 1 || de !== 6 || bc !== 6) begin
      tests_failed++;
      $display("FAIL amt0: dataOut=%h done_cnt=%0d edge=%0d busy=%0d, required DEADBEEF 1 6 6", dataOut, dc, de, bc);
    end
    tests_run++;
    if (pd !== 32'hEADBEEF0) begin
      tests_failed++;
      $display("FAIL amt0_pre_hold: dataOut before done %h, required EADBEEF0", pd);
    end
  endtask

  task automatic test_non_sll();
    int bc, dc, de;
    logic [31:0] pd;
    start_op(32'h12345678, 32'd8, 6'b000010);
    observe(bc, dc, de, pd);
    tests_run++;
    if (dataOut !== 32'h00000000 || dc !== 1 || de !== 6 || bc !== 6) begin
      tests_failed++;
      $display("FAIL srl_code: dataOut=%h done_cnt=%0d edge=%0d busy=%0d, required 00000000 1 6 6", dataOut, dc, de, bc);
    end
  endtask

  task automatic test_start_while_busy();
    int dc, de, bc;
    int dc2, de2, bc2;
    logic [31:0] pd;
    start_op(32'h0000000F, 32'd4, 6'b000000);
    dc = 0;
    de = 0;
    bc = 1;
    @(posedge clk);
    #1;
    if (busy) bc++;
    if (done) begin dc++; de = 2; end
    @(negedge clk);
    dataA = 32'hFFFFFFFF;
    dataB = 32'd1;
    Signal = 6'b000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy) bc++;
    if (done) begin dc++; de = 3; end
    for (int i = 4; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (busy) bc++;
      if (done) begin dc++; de = i; end
    end
    tests_run++;
    if (dc !== 1 || de !== 6 || bc !== 6) begin
      tests_failed++;
      $display("FAIL busy_ignore_done: count=%0d edge=%0d busy=%0d, required 1 6 6", dc, de, bc);
    end
    tests_run++;
    if (dataOut !== 32'h000000F0) begin
      tests_failed++;
      $display("FAIL busy_ignore_result: got %h, required 000000F0", dataOut);
    end
    start_op(32'h00000003, 32'd2, 6'b000000);
    observe(bc2, dc2, de2, pd);
    tests_run++;
    if (dataOut !== 32'h0000000C || dc2 !== 1 || de2 !== 6) begin
      tests_failed++;
      $display("FAIL after_ignore: dataOut=%h done_cnt=%0d edge=%0d, required 0000000C 1 6", dataOut, dc2, de2);
    end
  endtask

  task automatic test_async_abort();
    int dc, bc, de;
    logic [31:0] pd;
    start_op(32'hAAAAAAAA, 32'd3, 6'b000000);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    tests_run++;
    if (dataOut !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_immediate: dataOut=%h busy=%b done=%b, required 0/0/0", dataOut, busy, done);
    end
    dc = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dc++;
    end
    tests_run++;
    if (dc !== 0 || dataOut !== 32'h0) begin
      tests_failed++;
      $display("FAIL abort_no_done: stray done/busy=%0d dataOut=%h, required 0 and 00000000", dc, dataOut);
    end
    start_op(32'h00000001, 32'd2, 6'b000000);
    observe(bc, dc, de, pd);
    tests_run++;
    if (dataOut !== 32'h00000004 || dc !== 1 || de !== 6) begin
      tests_failed++;
      $display("FAIL abort_recover: dataOut=%h done_cnt=%0d edge=%0d, required 00000004 1 6", dataOut, dc, de);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_max_shift();
    test_amounts();
    test_non_sll();
    test_start_while_busy();
    test_async_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
